// File: rtl/async_evt_pkg.sv
// Shared types and constants for the asynchronous event timestamper.
package async_evt_pkg;

  localparam int unsigned TS_W_DEF  = 16;
  localparam int unsigned DEPTH_DEF = 8;
  localparam int unsigned FILL_W    = $clog2(DEPTH_DEF) + 1;

  typedef logic [TS_W_DEF-1:0] ts_t;

  // Occupancy width: one extra bit so a full FIFO (fill == depth) is representable.
  function automatic int unsigned fill_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/async_evt_stamp_if.sv
// Valid/ready timestamp stream between the event stamper and its consumer.
interface async_evt_stamp_if
  import async_evt_pkg::*;
#(
  parameter int unsigned TS_W = TS_W_DEF
);
  logic            evt_valid;
  logic [TS_W-1:0] evt_ts;
  logic            evt_ready;

  modport master (output evt_valid, output evt_ts, input evt_ready);
  modport slave  (input evt_valid, input evt_ts, output evt_ready);
endinterface

// File: rtl/async_evt_fifo.sv
// Synchronous FIFO with registered write, extra-bit pointers and occupancy output.
module async_evt_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned FILL_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata,
  output logic              full,
  output logic              empty,
  output logic [FILL_W-1:0] fill
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("async_evt_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers differ only in the wrap bit when full.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign fill    = wr_ptr - rd_ptr;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // Head reads as zero when empty so the output is clean after reset and drain.
  assign rdata   = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

  // Pointer update; clear wins over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; unreset since empty masks the head.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr[PTR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/async_evt_stamp.sv
// Resynchronises an asynchronous event flag, timestamps each rising edge and buffers
// the stamps for a valid/ready consumer, with accepted/dropped event accounting.
// Optional build macro ASYNC_EVT_HOLDOFF_EN adds HOLDOFF cycles of event blanking.
module async_evt_stamp
  import async_evt_pkg::*;
#(
  parameter int unsigned TS_W    = TS_W_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned OVF_W   = 8,
  parameter int unsigned HOLDOFF = 4,
  localparam int unsigned FW     = fill_width(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pulse_in,
  input  logic                clr_in,
  async_evt_stamp_if.master   evt,
  output logic [15:0]         evt_count,
  output logic [OVF_W-1:0]    ovf_cnt,
  output logic                ovf_flag,
  output logic [FW-1:0]       fill
);

  logic            s1, s2, s3;
  logic            rise;
  logic            rise_ok;
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] head_ts;
  logic            full;
  logic            empty;
  logic            pop;
  logic            accept;
  logic            drop;

  // Two-flop synchroniser plus one delay flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pulse_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  // Free-running timestamp; untouched by clr_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_cnt <= '0;
    else        ts_cnt <= ts_cnt + 1'b1;
  end

`ifdef ASYNC_EVT_HOLDOFF_EN
  localparam int unsigned HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  logic [HW-1:0] hold_cnt;

  assign rise_ok = rise & (hold_cnt == '0);

  // Blanking counter reloads on every processed rise, accepted or dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 hold_cnt <= '0;
    else if (clr_in)            hold_cnt <= '0;
    else if (rise_ok)           hold_cnt <= HW'(HOLDOFF);
    else if (hold_cnt != '0)    hold_cnt <= hold_cnt - 1'b1;
  end
`else
  assign rise_ok = rise;
`endif

  assign pop    = evt.evt_valid & evt.evt_ready;
  // A pop in the same cycle frees a slot, so full only drops when nothing leaves.
  assign accept = rise_ok & ~clr_in & (~full | pop);
  assign drop   = rise_ok & ~clr_in & full & ~pop;

  async_evt_fifo #(
    .WIDTH (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_in),
    .push  (accept),
    .pop   (pop),
    .wdata (ts_cnt),
    .rdata (head_ts),
    .full  (full),
    .empty (empty),
    .fill  (fill)
  );

  assign evt.evt_valid = ~empty;
  assign evt.evt_ts    = head_ts;

  // Accepted-event and overflow accounting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_count <= '0;
      ovf_cnt   <= '0;
      ovf_flag  <= 1'b0;
    end else if (clr_in) begin
      evt_count <= '0;
      ovf_cnt   <= '0;
      ovf_flag  <= 1'b0;
    end else begin
      if (accept) evt_count <= evt_count + 16'd1;
      if (drop) begin
        if (ovf_cnt != {OVF_W{1'b1}}) ovf_cnt <= ovf_cnt + 1'b1;
        ovf_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_async_evt_stamp.sv
// Directed bench for async_evt_stamp with a queue-based reference model.
module tb_async_evt_stamp;
  import async_evt_pkg::*;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned OVF_W   = 8;
  localparam int unsigned HOLDOFF = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pulse_in = 1'b0;
  logic              clr_in = 1'b0;
  logic [15:0]       evt_count;
  logic [OVF_W-1:0]  ovf_cnt;
  logic              ovf_flag;
  logic [FILL_W-1:0] fill;

  async_evt_stamp_if #(.TS_W(TS_W_DEF)) evt_if ();

  async_evt_stamp #(
    .TS_W    (TS_W_DEF),
    .DEPTH   (DEPTH),
    .OVF_W   (OVF_W),
    .HOLDOFF (HOLDOFF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pulse_in  (pulse_in),
    .clr_in    (clr_in),
    .evt       (evt_if),
    .evt_count (evt_count),
    .ovf_cnt   (ovf_cnt),
    .ovf_flag  (ovf_flag),
    .fill      (fill)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a rise is seen at edge n when pulse_in was sampled high at edge
  // n-2 and low at edge n-3; its stamp is the number of edges before it (n-1).
  ts_t mq[$];
  bit  hist[$];
  int  edge_n = 0;
  int  m_count = 0;
  int  m_ovf = 0;
  bit  m_flag = 0;
  int  hold = 0;

  function automatic bit samp(input int k);
    if (k >= 1 && k <= hist.size()) return hist[k-1];
    return 1'b0;
  endfunction

  initial begin
    forever begin
      bit rise;
      bit ok;
      bit do_pop;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        hist.delete();
        edge_n = 0; m_count = 0; m_ovf = 0; m_flag = 0; hold = 0;
      end else begin
        edge_n++;
        rise   = samp(edge_n - 2) && !samp(edge_n - 3);
        ok     = rise;
`ifdef ASYNC_EVT_HOLDOFF_EN
        ok     = rise && (hold == 0);
`endif
        do_pop = evt_if.evt_ready && (mq.size() != 0);
        if (clr_in) begin
          mq.delete();
          m_count = 0; m_ovf = 0; m_flag = 0; hold = 0;
        end else begin
          if (do_pop) void'(mq.pop_front());
          if (ok) begin
            if (mq.size() < DEPTH) begin
              mq.push_back(ts_t'(edge_n - 1));
              m_count = (m_count + 1) % 65536;
            end else begin
              if (m_ovf < 255) m_ovf++;
              m_flag = 1'b1;
            end
            hold = HOLDOFF;
          end else if (hold > 0) begin
            hold--;
          end
        end
        hist.push_back(pulse_in);
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("m_valid", {31'd0, evt_if.evt_valid}, {31'd0, mq.size() != 0});
        if (mq.size() != 0) chk("m_ts", {16'd0, evt_if.evt_ts}, {16'd0, mq[0]});
        chk("m_fill", {28'd0, fill}, mq.size());
        chk("m_count", {16'd0, evt_count}, m_count);
        chk("m_ovf", {24'd0, ovf_cnt}, m_ovf);
        chk("m_flag", {31'd0, ovf_flag}, {31'd0, m_flag});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic pulse(input int gap);
    pulse_in = 1'b1;
    cyc(2);
    pulse_in = 1'b0;
    cyc(gap);
  endtask

  ts_t ts_seen [3];

  initial begin
    evt_if.evt_ready = 1'b0;
    #1;
    chk("rst_valid", {31'd0, evt_if.evt_valid}, 0);
    chk("rst_fill", {28'd0, fill}, 0);
    #4 rst_n = 1'b1;                 // t=5, first edge at 10
    #10 pulse_in = 1'b1;             // t=15, sampled at edges 2 and 3
    #40 pulse_in = 1'b0;             // t=55
    #6;                              // t=61, rise still in flight
    chk("single_pre_valid", {31'd0, evt_if.evt_valid}, 0);
    #20;                             // t=81, pushed at edge 4 (t=70)
    chk("single_valid", {31'd0, evt_if.evt_valid}, 1);
    chk("single_ts", {16'd0, evt_if.evt_ts}, 3);
    chk("single_count", {16'd0, evt_count}, 1);
    #1 evt_if.evt_ready = 1'b1;
    cyc(1);
    evt_if.evt_ready = 1'b0;
    chk("single_drained", {31'd0, evt_if.evt_valid}, 0);

    // Three events five cycles apart, held, then drained in order.
    pulse(3); pulse(3); pulse(3);
    chk("b2b_fill", {28'd0, fill}, 3);
    chk("b2b_count", {16'd0, evt_count}, 4);
    for (int i = 0; i < 3; i++) begin
      ts_seen[i] = evt_if.evt_ts;
      evt_if.evt_ready = 1'b1;
      cyc(1);
    end
    evt_if.evt_ready = 1'b0;
    chk("b2b_gap0", {16'd0, ts_t'(ts_seen[1] - ts_seen[0])}, 5);
    chk("b2b_gap1", {16'd0, ts_t'(ts_seen[2] - ts_seen[1])}, 5);
    chk("b2b_empty", {28'd0, fill}, 0);

    // Ready while empty does nothing.
    evt_if.evt_ready = 1'b1;
    cyc(4);
    evt_if.evt_ready = 1'b0;
    chk("empty_ready_count", {16'd0, evt_count}, 4);

    // Overflow: ten events into eight slots.
    clr_in = 1'b1; cyc(1); clr_in = 1'b0;
    chk("clr_count", {16'd0, evt_count}, 0);
    for (int i = 0; i < 10; i++) pulse(2);
    cyc(2);
    chk("ovf_fill", {28'd0, fill}, 8);
    chk("ovf_count", {16'd0, evt_count}, 8);
    chk("ovf_cnt", {24'd0, ovf_cnt}, 2);
    chk("ovf_flag", {31'd0, ovf_flag}, 1);

    // Rise coincident with a pop while full is accepted.
    pulse_in = 1'b1;
    cyc(2);
    pulse_in = 1'b0;
    evt_if.evt_ready = 1'b1;
    cyc(1);
    evt_if.evt_ready = 1'b0;
    cyc(2);
    chk("fullpop_fill", {28'd0, fill}, 8);
    chk("fullpop_ovf", {24'd0, ovf_cnt}, 2);
    chk("fullpop_count", {16'd0, evt_count}, 9);

    // Drain to five entries, then clear.
    evt_if.evt_ready = 1'b1; cyc(3); evt_if.evt_ready = 1'b0;
    chk("pre_clr_fill", {28'd0, fill}, 5);
    clr_in = 1'b1; cyc(1); clr_in = 1'b0;
    chk("clr_fill", {28'd0, fill}, 0);
    chk("clr_valid", {31'd0, evt_if.evt_valid}, 0);
    chk("clr_ovf", {24'd0, ovf_cnt}, 0);
    chk("clr_flag", {31'd0, ovf_flag}, 0);

    // Rise landing in the clear cycle is discarded.
    pulse_in = 1'b1; cyc(2); pulse_in = 1'b0;
    clr_in = 1'b1; cyc(1); clr_in = 1'b0;
    cyc(2);
    chk("clr_rise_count", {16'd0, evt_count}, 0);

    // Rises 3 cycles then 6 cycles apart.
    pulse(1); pulse(4); pulse(4); pulse(4);
    cyc(2);
`ifdef ASYNC_EVT_HOLDOFF_EN
    chk("holdoff_count", {16'd0, evt_count}, 3);
`else
    chk("holdoff_count", {16'd0, evt_count}, 4);
`endif

    // Asynchronous reset in the middle of a drain.
    clr_in = 1'b1; cyc(1); clr_in = 1'b0;
    pulse(2); pulse(2); pulse(2);
    cyc(2);
    evt_if.evt_ready = 1'b1;
    cyc(1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, evt_if.evt_valid}, 0);
    chk("arst_ts", {16'd0, evt_if.evt_ts}, 0);
    chk("arst_fill", {28'd0, fill}, 0);
    chk("arst_count", {16'd0, evt_count}, 0);
    chk("arst_ovf", {24'd0, ovf_cnt}, 0);
    chk("arst_flag", {31'd0, ovf_flag}, 0);
    #5 rst_n = 1'b1;
    evt_if.evt_ready = 1'b0;
    cyc(3);
    pulse(4);
    chk("post_rst_count", {16'd0, evt_count}, 1);
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
